// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter feeding a one-entry valid/ready output register.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (d0 always wins).
module rr_arb2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d0,
   input  logic             d0_valid,
   output logic             d0_ready,
   input  logic [WIDTH-1:0] d1,
   input  logic             d1_valid,
   output logic             d1_ready,
   output logic             sel,
   output logic [WIDTH-1:0] out,
   output logic             out_src,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] out_r;
   logic             out_src_r;
   logic             space_s;
   logic             any_s;
   logic             load_s;
   logic             sel_s;

`ifndef ARB_FIXED_PRIO_EN
   logic             last_r;
`endif

   // Grant selection and handshake decode; depends only on valids, output state and priority.
   always_comb begin
      space_s = (state_r == EMPTY) | out_ready;
      any_s   = d0_valid | d1_valid;
      load_s  = space_s & any_s;
`ifdef ARB_FIXED_PRIO_EN
      sel_s   = ~d0_valid;
`else
      if (d0_valid && !d1_valid) begin
         sel_s = 1'b0;
      end else if (!d0_valid && d1_valid) begin
         sel_s = 1'b1;
      end else begin
         // Contention or idle: the channel not served last wins.
         sel_s = ~last_r;
      end
`endif
   end

   // Output register and its EMPTY/FULL state; a drain and a load can share one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= EMPTY;
         out_r     <= {WIDTH{1'b0}};
         out_src_r <= 1'b0;
      end else if (load_s) begin
         state_r   <= FULL;
         out_r     <= sel_s ? d1 : d0;
         out_src_r <= sel_s;
      end else if ((state_r == FULL) && out_ready) begin
         state_r   <= EMPTY;
      end else begin
         state_r   <= state_r;
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   // Last-served pointer moves only when a word is actually taken, so idle cycles keep priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_r <= 1'b1;
      end else if (load_s) begin
         last_r <= sel_s;
      end else begin
         last_r <= last_r;
      end
   end
`endif

   assign sel       = sel_s;
   assign d0_ready  = load_s & ~sel_s;
   assign d1_ready  = load_s & sel_s;
   assign out       = out_r;
   assign out_src   = out_src_r;
   assign out_valid = (state_r == FULL);

endmodule

// File: doc/rr_arb2.md
# rr_arb2

Two-input round-robin arbiter with a registered output stage. It accepts WIDTH-bit words from two valid/ready source channels and selects one per cycle. It forwards the selected word through a one-entry output register to a valid/ready sink. It also exports the live select bit so that a downstream 2:1 multiplexer on a parallel datapath can steer companion data in lock-step.

## Interface

Parameters:

- WIDTH, 8, data word width in bits.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- d0  in  WIDTH  channel 0 data.
- d0_valid  in  1  channel 0 word present.
- d0_ready  out  1  channel 0 word accepted this cycle.
- d1  in  WIDTH  channel 1 data.
- d1_valid  in  1  channel 1 word present.
- d1_ready  out  1  channel 1 word accepted this cycle.
- sel  out  1  combinational grant: 0 selects d0, 1 selects d1. Meaningful only when load is high.
- out  out  WIDTH  registered output word.
- out_src  out  1  channel that produced the word held in out.
- out_valid  out  1  out holds a word.
- out_ready  in  1  sink accepts out this cycle.

## Operation

- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Definitions:
  - space = !out_valid | out_ready. The register can take a word this cycle, including a same-cycle drain.
  - any = d0_valid | d1_valid.
  - load = space & any.
- Grant (combinational), using the last-served pointer `last`:
  - Only d0_valid: sel=0.
  - Only d1_valid: sel=1.
  - Both valid: sel = !last, i.e. the channel not served last wins.
  - Neither valid: sel = !last. Don't-care for consumers.
- Ready outputs:
  - d0_ready = load & (sel==0).
  - d1_ready = load & (sel==1).
  - At most one ready is high in any cycle.
- On the clock edge with load=1:
  - out ← sel ? d1 : d0.
  - out_src ← sel.
  - last ← sel.
  - State becomes FULL.
- On the clock edge with load=0:
  - If out_valid & out_ready, state becomes EMPTY.
  - Otherwise out, out_src and state hold.
- `last` updates only on load. Idle cycles never rotate priority.
- The data path is a pure 2:1 select of d0/d1. No arithmetic, no width change.
- Inputs do not need to be stable while not granted. A source may drop valid before it is granted (no protocol check).
- Reset mid-transfer: the held word is discarded and `last` returns to its reset value.

## Timing

- Reset values:
  - out=0, out_src=0, out_valid=0, last=1.
  - With last=1, d0 wins the first contention.
- Latency: 1 cycle. A word accepted at edge N is visible on out with out_valid=1 after edge N.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Back-pressure:
  - FULL with out_ready=0 gives space=0, so both readies are 0 and out is stable.
  - out may change only on an edge where out_valid & out_ready was high, or while out_valid=0.
- Simultaneous drain and load: FULL with out_ready=1 and any=1 loads the new word on the same edge, with no bubble.
- Simultaneous valids with continuous out_ready: grants alternate 0,1,0,1,… starting with 0 after reset.
- d*_ready and sel are combinational from d*_valid, out_valid, out_ready and `last`. There is no combinational path from d0/d1 data to any output.

## Configuration

- ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. sel = !d0_valid, so d0 always wins when valid. `last` is not implemented, and out_src still reports the source.
  - Undefined (default): round-robin as described above.

## Test plan

- Reset release, no valids → out_valid=0, out=0, out_src=0, d0_ready=d1_ready=0.
- d0_valid=1 with d0=0x3C, out_ready=1 → d0_ready=1 and sel=0 that cycle; next cycle out=0x3C, out_src=0, out_valid=1.
- Both valid every cycle (d0=0xA0.., d1=0xB0.., incrementing), out_ready=1 for 6 cycles → out_src sequence 0,1,0,1,0,1, with each channel's words in order and none dropped or duplicated.
- FULL with out=0x55, out_ready=0 for 3 cycles while both inputs valid → both readies 0 and out=0x55 stable. Then out_ready=1 → drain and load on the same edge, with no empty cycle.
- Assert rst asynchronously mid-stream while FULL → out_valid=0 and out=0 immediately, without waiting for a clock edge. The next contention grants d0.
- With ARB_FIXED_PRIO_EN defined, both valid for 4 cycles → out_src=0 for all 4 and d1_ready stays 0.
